// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: resolves load-use,
// taken-branch, mul/div occupancy and imem wait hazards and counts stall cycles.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             imem_ready,
  input  logic             stall_cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_MDIV_WAIT = 2'd2
  } state_t;

  // The start cycle counts as the first stalled cycle, so the wait counter
  // is loaded two short of the total.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);

  state_t           r_state;
  logic [7:0]       r_md_cnt;
  logic             r_md_release;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_md_go;

  assign w_load_use = ex_mem_read & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign w_md_go    = md_start & ~r_md_release;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      ST_RUN: begin
        if (w_md_go) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (!imem_ready) begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      ST_MDIV_WAIT: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        busy         = 1'b1;
      end
      default: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_md_cnt     <= 8'd0;
      r_md_release <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_md_release <= 1'b0;
      unique case (r_state)
        ST_INIT: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_md_go) begin
            r_md_cnt <= MD_LOAD;
            r_state  <= ST_MDIV_WAIT;
          end
        end
        ST_MDIV_WAIT: begin
          if (r_md_cnt == 8'd0) begin
            r_state      <= ST_RUN;
            r_md_release <= 1'b1;
          end else begin
            r_md_cnt <= r_md_cnt - 8'd1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held outside of INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_INIT) && !pc_write && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors are queued as
// stimulus is applied and popped when the combinational response is sampled.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, md_start, imem_ready, stall_cnt_clr;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, busy;
  logic [15:0] stall_cnt;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_write, b_idex_bubble;
  logic        b_exmem_bubble, b_busy;
  logic [3:0]  b_stall_cnt;

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .md_start(md_start), .imem_ready(imem_ready), .stall_cnt_clr(stall_cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .md_start(md_start), .imem_ready(imem_ready), .stall_cnt_clr(stall_cnt_clr),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .idex_write(b_idex_write), .idex_bubble(b_idex_bubble), .exmem_bubble(b_exmem_bubble),
    .busy(b_busy), .stall_cnt(b_stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, busy}
  localparam logic [6:0] V_INIT   = 7'b0011100;
  localparam logic [6:0] V_RUN    = 7'b1101000;
  localparam logic [6:0] V_MDGO   = 7'b0000010;
  localparam logic [6:0] V_MDWAIT = 7'b0000011;
  localparam logic [6:0] V_BRANCH = 7'b1111100;
  localparam logic [6:0] V_LDUSE  = 7'b0001100;
  localparam logic [6:0] V_IMEM   = 7'b0111000;

  wire [6:0] w_obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                      exmem_bubble, busy};

  typedef struct packed {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       br;
    logic       imem;
    logic [6:0] exp;
  } stim_t;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  int         cnt_q[$];
  logic [6:0] exp_v;
  int         exp_c;
  stim_t      tbl[0:5];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; md_start = 1'b0; imem_ready = 1'b1; stall_cnt_clr = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    ex_mem_read = s.mr; ex_rt = s.ex_rt; id_rs = s.rs; id_rt = s.rt;
    id_uses_rt = s.ur; branch_taken = s.br; imem_ready = s.imem; md_start = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) begin
      exp_q.push_back(V_INIT);
      next_cycle();
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL reset_hold: got %b want %b", w_obs, exp_v);
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(V_INIT);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (w_obs !== exp_v) begin
      errors++; $display("FAIL reset_first_cycle: got %b want %b", w_obs, exp_v);
    end
    exp_q.push_back(V_RUN);
    cnt_q.push_back(0);
    next_cycle();
    #2;
    exp_v = exp_q.pop_front(); checks++;
    if (w_obs !== exp_v) begin
      errors++; $display("FAIL reset_run: got %b want %b", w_obs, exp_v);
    end
    exp_c = cnt_q.pop_front(); checks++;
    if (stall_cnt !== 16'(exp_c)) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d want %0d", stall_cnt, exp_c);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    tbl[0] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, V_LDUSE};
    tbl[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, V_RUN};
    tbl[2] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1, V_RUN};
    tbl[3] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, V_LDUSE};
    tbl[4] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, V_LDUSE};
    tbl[5] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, V_RUN};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL load_use[%0d]: got %b want %b", i, w_obs, exp_v);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_branch_imem();
    tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_BRANCH};
    tbl[1] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_IMEM};
    tbl[2] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, V_BRANCH};
    tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, V_RUN};
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL branch_imem[%0d]: got %b want %b", i, w_obs, exp_v);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_muldiv();
    idle();
    stall_cnt_clr = 1'b1;
    next_cycle();
    stall_cnt_clr = 1'b0;
    md_start = 1'b1;
    exp_q.push_back(V_MDGO);
    exp_q.push_back(V_MDWAIT);
    exp_q.push_back(V_MDWAIT);
    exp_q.push_back(V_MDWAIT);
    exp_q.push_back(V_RUN);
    for (int c = 1; c <= 5; c++) begin
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL muldiv_cycle%0d: got %b want %b", c, w_obs, exp_v);
      end
      next_cycle();
    end
    md_start = 1'b0;
    exp_q.push_back(V_RUN);
    cnt_q.push_back(4);
    #2;
    exp_v = exp_q.pop_front(); checks++;
    if (w_obs !== exp_v) begin
      errors++; $display("FAIL muldiv_after: got %b want %b", w_obs, exp_v);
    end
    exp_c = cnt_q.pop_front(); checks++;
    if (stall_cnt !== 16'(exp_c)) begin
      errors++; $display("FAIL muldiv_stall_cnt: got %0d want %0d", stall_cnt, exp_c);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_muldiv();
    idle();
    md_start = 1'b1;
    exp_q.push_back(V_MDGO);
    exp_q.push_back(V_MDWAIT);
    exp_q.push_back(V_MDWAIT);
    for (int c = 1; c <= 3; c++) begin
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL mdrst_cycle%0d: got %b want %b", c, w_obs, exp_v);
      end
      if (c < 3) next_cycle();
      md_start = 1'b0;
    end
    rst_n = 1'b0;
    exp_q.push_back(V_INIT);
    cnt_q.push_back(0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (w_obs !== exp_v) begin
      errors++; $display("FAIL mdrst_init: got %b want %b", w_obs, exp_v);
    end
    exp_c = cnt_q.pop_front(); checks++;
    if (stall_cnt !== 16'(exp_c)) begin
      errors++; $display("FAIL mdrst_stall_cnt: got %0d want %0d", stall_cnt, exp_c);
    end
    next_cycle();
    rst_n = 1'b1;
    exp_q.push_back(V_INIT);
    exp_q.push_back(V_RUN);
    for (int c = 0; c < 2; c++) begin
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL mdrst_recover%0d: got %b want %b", c, w_obs, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_saturation();
    idle();
    imem_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back(V_IMEM);
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL sat_imem%0d: got %b want %b", c, w_obs, exp_v);
      end
      next_cycle();
    end
    cnt_q.push_back(15); cnt_q.push_back(20);
    cnt_q.push_back(15); cnt_q.push_back(21);
    cnt_q.push_back(0);  cnt_q.push_back(0);
    for (int k = 0; k < 3; k++) begin
      #2;
      exp_c = cnt_q.pop_front(); checks++;
      if (b_stall_cnt !== 4'(exp_c)) begin
        errors++; $display("FAIL sat_cnt4_%0d: got %0d want %0d", k, b_stall_cnt, exp_c);
      end
      exp_c = cnt_q.pop_front(); checks++;
      if (stall_cnt !== 16'(exp_c)) begin
        errors++; $display("FAIL sat_cnt16_%0d: got %0d want %0d", k, stall_cnt, exp_c);
      end
      if (k == 1) stall_cnt_clr = 1'b1;
      next_cycle();
      stall_cnt_clr = 1'b0;
    end
    idle();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_load_use();
    test_branch_imem();
    test_muldiv();
    test_reset_mid_muldiv();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the write-enable and flush/bubble controls of the PC, the IF/ID register, the ID/EX register and the EX/MEM register.
- Resolves four hazard sources: load-use data hazards, taken branches resolved in EX, multi-cycle mul/div occupancy of EX, and instruction-memory wait states.
- Also keeps a saturating stall-cycle statistics counter.

Parameters:
- MD_CYCLES, 4: number of cycles the pipeline is stalled per mul/div. Legal range is 2..255.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  the ID instruction reads rt as a source.
- ex_mem_read  input  1  the EX instruction is a load.
- ex_rt  input  5  destination rt of the EX instruction.
- branch_taken  input  1  the EX branch/jump resolved as taken.
- md_start  input  1  the EX instruction is mul/div.
- imem_ready  input  1  instruction memory returns valid data this cycle.
- stall_cnt_clr  input  1  synchronous clear of stall_cnt.
- pc_write  output  1  PC load enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID loads NOP. Overrides ifid_write.
- idex_write  output  1  ID/EX load enable.
- idex_bubble  output  1  ID/EX loads NOP. Overrides idex_write.
- exmem_bubble  output  1  EX/MEM loads NOP.
- busy  output  1  mul/div wait in progress.
- stall_cnt  output  CNT_W  number of cycles with pc_write=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- State reset values: FSM = INIT, md_cnt = 0, md_release = 0, stall_cnt = 0.
- Outputs are combinational from state and current inputs, so the response has zero latency within the same cycle.
- Default outputs: pc_write=1, ifid_write=1, idex_write=1; all flush/bubble outputs = 0.
- State INIT (held throughout reset, and for the first cycle after rst_n rises):
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=0, busy=0.
  - Next state: RUN.
- State RUN evaluates hazards in priority order. Only the highest-priority active hazard applies.
  - 1. md_start=1 and md_release=0:
    - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
    - md_cnt <= MD_CYCLES-2; next state MDIV_WAIT.
  - 2. branch_taken=1:
    - Outputs: pc_write=1, ifid_flush=1, idex_bubble=1.
    - Applies regardless of imem_ready.
  - 3. Load-use: ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
    - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
    - ifid_flush=0, even if imem_ready=0.
  - 4. imem_ready=0:
    - Outputs: pc_write=0, ifid_flush=1.
    - ID/EX and later stages proceed.
  - md_start with branch_taken in the same cycle is illegal stimulus; md_start wins.
- State MDIV_WAIT:
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, busy=1.
  - All other inputs are ignored.
  - If md_cnt==0: next state RUN and md_release <= 1. Otherwise md_cnt decrements.
- Stall length and release:
  - Total stalled cycles per mul/div = MD_CYCLES (the md_start cycle plus MD_CYCLES-1 wait cycles).
  - md_release is 1 for exactly the first RUN cycle after MDIV_WAIT. In that cycle md_start is ignored, so the instruction exits EX.
  - md_release clears on the next edge.
- md_cnt width: 8 bits.
- stall_cnt:
  - Increments on each rising edge where the state is not INIT and pc_write=0.
  - Saturates at all-ones.
  - stall_cnt_clr=1 zeroes it on the next edge and wins over increment.
- Reset asserted mid-operation: immediate return to INIT with INIT outputs. Any mul/div in flight is discarded.

Test Plan:
- Reset then run:
  - Stimulus: rst_n low 3 cycles, then high; all hazard inputs 0, imem_ready=1.
  - Required: first cycle after release has pc_write=0, ifid_flush=1, idex_bubble=1. From the second cycle, pc_write=1 and ifid_write=1. stall_cnt=0.
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rt=8, id_rs=8.
  - Required: pc_write=0, ifid_write=0, idex_bubble=1 in the same cycle.
  - Repeat with ex_rt=0, or with id_rt=8 and id_uses_rt=0 → no stall.
- Branch with memory wait:
  - Stimulus: branch_taken=1, imem_ready=0.
  - Required: pc_write=1, ifid_flush=1, idex_bubble=1.
  - Next cycle, with branch_taken=0 and imem_ready=0: pc_write=0, ifid_flush=1, idex_bubble=0.
- Mul/div:
  - Stimulus: MD_CYCLES=4; md_start held high for 5 cycles.
  - Required: exactly 4 cycles with exmem_bubble=1 and pc_write=0; busy=1 for cycles 2-4. Cycle 5 has all write enables 1 (release). stall_cnt=4.
  - Also assert rst_n low during cycle 3 → INIT immediately; busy=0.
- Counter saturation and clear:
  - Stimulus: CNT_W=4; imem_ready=0 for 20 cycles.
  - Required: stall_cnt=15, held.
  - Then stall_cnt_clr=1 coincident with another stall cycle → stall_cnt=0.
